nibble_serial_adder_ctrl: RTL and testbench
===========================================

// Module: nibble_serial_adder_ctrl
// PURPOSE
//   Sequencer that performs a wide add/subtract through one shared 4-bit ripple adder
//   (full_adder), one nibble per clock, LSB nibble first.
//   - Carry is held in a register between nibbles.
//   - Start/busy/done handshake toward the requesting logic.
//   - Sits between the course-project control FSM and the existing 4-bit adder datapath.
// PARAMETERS
//   NIBBLES  4  number of 4-bit slices; operand width W = 4*NIBBLES (NIBBLES >= 1)
// PORTS
//   clk       in   1  single clock; all state updates on the rising edge
//   rst       in   1  synchronous, active-high reset
//   start     in   1  request; sampled only when busy==0
//   sub       in   1  0: A+B, 1: A-B; sampled with start
//   a         in   W  operand A; sampled with start
//   b         in   W  operand B; sampled with start
//   busy      out  1  high while slices are being processed
//   done      out  1  one-cycle pulse: result/cout/overflow are valid
//   result    out  W  sum/difference; held until the next accepted start
//   cout      out  1  final carry (for sub: 1 = no borrow, i.e. A >= B unsigned)
//   overflow  out  1  signed two's-complement overflow of the W-bit operation
// BEHAVIOUR
//   Reset
//   - One clk edge with rst=1 forces state IDLE.
//   - busy=0, done=0, result=0, cout=0, overflow=0.
//   - The slice index and the carry register are also cleared.
//   - rst has priority over everything, including an operation in progress (it is aborted).
//   States: IDLE, RUN, DONE.
//   IDLE/DONE -> RUN when start=1 at the edge.
//   - Latch opA=a and opB = sub ? ~b : b.
//   - carry <= sub; idx <= 0.
//   - result is not cleared on accept.
//   RUN, each edge:
//   - Adder inputs: A=opA[4*idx+:4], B=opB[4*idx+:4], cin=carry.
//   - result[4*idx+:4] <= sum; carry <= co; idx <= idx+1.
//   - At idx==NIBBLES-1 the state goes to DONE instead.
//   - On that last edge: cout <= co, and overflow <= (opA[W-1]==opB[W-1]) && (sum[3]!=opA[W-1]).
//   DONE
//   - Lasts exactly one cycle with done=1, busy=0.
//   - Next state is IDLE, or RUN if start=1 (back-to-back issue allowed).
//   Outputs and timing
//   - busy=1 exactly in RUN.
//   - start while busy=1 is ignored; no queuing, and operands are not re-sampled.
//   - Latency: start accepted at edge t -> done high in the cycle after edge t+NIBBLES.
//   - Throughput: one op per NIBBLES+1 cycles.
//   - done and busy are never high together.
//   Widths and arithmetic
//   - result wraps modulo 2^W.
//   - Subtraction is two's complement: ~B plus carry-in 1.
//   - cout and overflow update only on the final slice; they are held otherwise.
//   - Edge case NIBBLES=1: RUN lasts a single cycle; the same rules apply.
// STRUCTURE
//   Shared package
//   - NIBBLE_W=4.
//   - State encoding constants IDLE=2'd0, RUN=2'd1, DONE=2'd2 (2'd3 is illegal and recovers to IDLE).
//   - Index width function clog2(NIBBLES) (minimum 1).
//   Sub-module
//   - One instance of the existing 4-bit full_adder as the shared datapath.
//   - This block holds only the FSM, operand/result registers, carry register and slice mux/demux.
// TESTING  (NIBBLES=4, W=16)
//   - 0x1234 + 0x4321, sub=0 -> after 4 busy cycles, done pulse; result=0x5555, cout=0, overflow=0.
//   - 0xFFFF + 0x0001 -> result=0x0000, cout=1, overflow=0.
//   - 0x7FFF + 0x0001 -> result=0x8000, cout=0, overflow=1.
//   - 0x0005 - 0x0007, sub=1 -> result=0xFFFE, cout=0, overflow=0.
//   - 0x8000 - 0x0001 -> result=0x7FFF, cout=1, overflow=1.
//   - start pulsed with new operands while busy -> ignored; the first result is unchanged and only one done pulse occurs.
//   - Back-to-back: start held high through DONE -> second op begins with no IDLE cycle.
//   - rst=1 during the 2nd RUN cycle -> next cycle busy=0, done=0, result=0.
//     The op is never completed, and a fresh start then works normally.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// nibble_serial_adder_ctrl_pkg: shared constants, state encoding and index-width helper
package nibble_serial_adder_ctrl_pkg;
    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int idx_width(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction
endpackage

// File: rtl/nibble_serial_adder_ctrl_full_adder.sv
// full_adder: 4-bit ripple adder shared by the serial sequencer
module full_adder
    import nibble_serial_adder_ctrl_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                co
);
    assign {co, sum} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};
endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl: wide add/subtract sequenced one nibble per clock,
// LSB first, through a single shared 4-bit full_adder.
module nibble_serial_adder_ctrl
    import nibble_serial_adder_ctrl_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        sub,
    input  logic [NIBBLE_W*NIBBLES-1:0] a,
    input  logic [NIBBLE_W*NIBBLES-1:0] b,
    output logic                        busy,
    output logic                        done,
    output logic [NIBBLE_W*NIBBLES-1:0] result,
    output logic                        cout,
    output logic                        overflow
);
    localparam int W  = NIBBLE_W * NIBBLES;
    localparam int IW = idx_width(NIBBLES);

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    opa_q, opa_d, opb_q, opb_d, result_q, result_d;
    logic            cout_q, cout_d, ovf_q, ovf_d;
    logic [NIBBLE_W-1:0] fa_a, fa_b, fa_sum;
    logic            fa_co, last;

    assign fa_a = opa_q[NIBBLE_W*idx_q +: NIBBLE_W];
    assign fa_b = opb_q[NIBBLE_W*idx_q +: NIBBLE_W];
    assign last = idx_q == IW'(NIBBLES - 1);

    full_adder u_fa (
        .a   (fa_a),
        .b   (fa_b),
        .cin (carry_q),
        .sum (fa_sum),
        .co  (fa_co)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = start ? RUN : IDLE;
                if (start) begin
                    opa_d   = a;
                    opb_d   = sub ? ~b : b;
                    carry_d = sub;
                    idx_d   = '0;
                end
            end
            RUN: begin
                result_d[NIBBLE_W*idx_q +: NIBBLE_W] = fa_sum;
                carry_d = fa_co;
                idx_d   = idx_q + IW'(1);
                if (last) begin
                    state_d = DONE;
                    cout_d  = fa_co;
                    // sign of the final nibble's sum is the sign of the full result
                    ovf_d   = (opa_q[W-1] == opb_q[W-1]) && (fa_sum[NIBBLE_W-1] != opa_q[W-1]);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy     = state_q == RUN;
    assign done     = state_q == DONE;
    assign result   = result_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb_nibble_serial_adder_ctrl: scoreboard bench with an arithmetic reference model
module tb_nibble_serial_adder_ctrl;
    localparam int N = 4;
    localparam int W = 4 * N;

    typedef struct packed {
        logic [W-1:0] r;
        logic         c;
        logic         v;
    } exp_t;

    logic clk = 1'b0;
    logic rst, start, sub, busy, done, cout, overflow;
    logic [W-1:0] a, b, result;

    exp_t q[$];
    int tests = 0, fails = 0, dones = 0, pushes = 0;

    always #5 clk = ~clk;

    nibble_serial_adder_ctrl #(.NIBBLES(N)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .cout(cout), .overflow(overflow)
    );

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        exp_t e;
        longint sx, sy, sr, ux, uy, ur;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'(x);
        uy = longint'(y);
        sr = s ? sx - sy : sx + sy;
        ur = s ? ux - uy + (longint'(1) << W) : ux + uy;
        e.r = ur[W-1:0];
        e.c = ur[W];
        e.v = (sr > (longint'(1) << (W - 1)) - 1) || (sr < -(longint'(1) << (W - 1)));
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        check("busy_done_exclusive", {31'b0, busy & done}, 32'd0);
        if (done) begin
            dones++;
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got result %h with empty scoreboard", result);
            end else begin
                e = q.pop_front();
                check("result", {16'b0, result}, {16'b0, e.r});
                check("cout", {31'b0, cout}, {31'b0, e.c});
                check("overflow", {31'b0, overflow}, {31'b0, e.v});
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", {31'b0, busy}, 32'd0);
    endtask

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                         input bit hold, input bit poke);
        wait_idle();
        a = x;
        b = y;
        sub = s;
        start = 1'b1;
        @(negedge clk);
        q.push_back(model(x, y, s));
        pushes++;
        if (!hold) start = 1'b0;
        for (int k = 0; k < N; k++) begin
            check("busy_run", {30'b0, busy, done}, 32'd2);
            if (poke && k == 1) begin
                start = 1'b1;
                a = W'($urandom);
                b = W'($urandom);
                sub = ~s;
            end
            if (poke && k == 2) start = 1'b0;
            @(negedge clk);
        end
        check("done_latency", {30'b0, busy, done}, 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        sub = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(negedge clk);
        check("reset_state", {busy, done, cout, overflow, 12'b0, result}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        issue(16'h1234, 16'h4321, 1'b0, 0, 0); @(negedge clk);
        issue(16'hFFFF, 16'h0001, 1'b0, 0, 0); @(negedge clk);
        issue(16'h7FFF, 16'h0001, 1'b0, 0, 0); @(negedge clk);
        issue(16'h0005, 16'h0007, 1'b1, 0, 0); @(negedge clk);
        issue(16'h8000, 16'h0001, 1'b1, 0, 0); @(negedge clk);
        issue(16'hA5A5, 16'h1111, 1'b0, 0, 1); @(negedge clk);
        issue(16'h0F0F, 16'h00F1, 1'b0, 1, 0);
        issue(16'h8000, 16'h8000, 1'b0, 0, 0); @(negedge clk);

        issue(16'h1111, 16'h2222, 1'b0, 0, 0);
        start = 1'b1;
        a = 16'hDEAD;
        b = 16'hBEEF;
        sub = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_state", {busy, done, cout, overflow, 12'b0, result}, 32'd0);
        repeat (6) @(negedge clk);
        check("abort_no_done", {31'b0, done}, 32'd0);
        issue(16'h0001, 16'h0002, 1'b0, 0, 0); @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            bit hold;
            hold = 1'($urandom);
            issue(W'($urandom), W'($urandom), 1'($urandom), hold, ($urandom % 4) == 0);
            if (!hold) repeat ($urandom % 3) @(negedge clk);
        end
        issue(W'($urandom), W'($urandom), 1'($urandom), 0, 0);

        repeat (4) @(negedge clk);
        check("done_count", dones, pushes);
        check("scoreboard_empty", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
